// File: rtl/fifo_flex_if.sv
// Handshake bundle for fifo_flex: producer/consumer requests plus status.
// The master side drives requests; the FIFO implements the slave side.
interface fifo_flex_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16
);
  logic                     clear;
  logic                     write;
  logic [DWIDTH-1:0]        din;
  logic                     full;
  logic                     almost_full;
  logic                     read;
  logic [DWIDTH-1:0]        dout;
  logic                     empty;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output clear, write, din, read,
    input  full, almost_full, dout, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, write, din, read,
    output full, almost_full, dout, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flex.sv
// Single-clock FIFO with registered or fall-through read, occupancy count,
// almost-full/almost-empty thresholds, synchronous clear and sticky errors.
module fifo_flex #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 16,
  parameter bit FWFT      = 1'b0,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input logic       clk,
  input logic       rst_n,
  fifo_flex_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_TH    = PW'(AFULL_TH);
  localparam logic [PW-1:0] AE_TH    = PW'(AEMPTY_TH);
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     wr_ptr_next, rd_ptr_next, count_next;
  logic [PW-1:0]     count_reg;
  logic              empty_reg, full_reg, almost_empty_reg, almost_full_reg;
  logic              overflow_reg, underflow_reg;
  logic [DWIDTH-1:0] hold_reg;
  logic [DWIDTH-1:0] head;
  logic              wr_accept, rd_accept;

  // Accept decisions use the registered (pre-edge) flags only, so a read
  // never makes room for a same-cycle write and vice versa.
  assign wr_accept = bus.write && !full_reg;
  assign rd_accept = bus.read && !empty_reg;
  assign head      = mem[rd_ptr[AW-1:0]];

  // Next pointers; occupancy is the pointer difference, with the extra MSB
  // telling a full FIFO (difference DEPTH) from an empty one.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (wr_accept) wr_ptr_next = wr_ptr + PW'(1);
    if (rd_accept) rd_ptr_next = rd_ptr + PW'(1);
    count_next = wr_ptr_next - rd_ptr_next;
  end

  // Storage write port; contents are never reset or cleared.
  always_ff @(posedge clk) begin
    if (wr_accept && !bus.clear) mem[wr_ptr[AW-1:0]] <= bus.din;
  end

  // Pointers, count, registered flags, sticky errors and read-data holder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
      hold_reg         <= '0;
    end else if (bus.clear) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      wr_ptr           <= wr_ptr_next;
      rd_ptr           <= rd_ptr_next;
      count_reg        <= count_next;
      empty_reg        <= (count_next == '0);
      full_reg         <= (count_next == FULL_CNT);
      almost_empty_reg <= (count_next <= AE_TH);
      almost_full_reg  <= (count_next >= AF_TH);
      if (bus.write && full_reg) overflow_reg <= 1'b1;
      if (bus.read && empty_reg) underflow_reg <= 1'b1;
      if (rd_accept) hold_reg <= head;
    end
  end

  // Registered mode shows the last popped word; fall-through mode shows the
  // head while data is present and the last popped word otherwise.
  generate
    if (FWFT) begin : g_fwft
      assign bus.dout = empty_reg ? hold_reg : head;
    end else begin : g_reg
      assign bus.dout = hold_reg;
    end
  endgenerate

  assign bus.count        = count_reg;
  assign bus.empty        = empty_reg;
  assign bus.full         = full_reg;
  assign bus.almost_empty = almost_empty_reg;
  assign bus.almost_full  = almost_full_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a registered-read and a fall-through instance share
// stimulus and are compared against a queue-based reference model.
module tb_fifo_flex;
  localparam int DW = 32;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_flex_if #(.DWIDTH(DW), .DEPTH(DP)) if0 ();
  fifo_flex_if #(.DWIDTH(DW), .DEPTH(DP)) if1 ();

  assign if1.clear = if0.clear;
  assign if1.write = if0.write;
  assign if1.din   = if0.din;
  assign if1.read  = if0.read;

  fifo_flex #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1'b0), .AFULL_TH(14), .AEMPTY_TH(2))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  fifo_flex #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1'b1), .AFULL_TH(14), .AEMPTY_TH(2))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Reference model: contents queue, last popped word, sticky errors.
  logic [DW-1:0] q[$];
  logic [DW-1:0] hold = '0;
  bit            ov = 0, un = 0;
  int            pushes = 0;

  function automatic logic [DW-1:0] exp_fwft_dout();
    return (q.size() != 0) ? q[0] : hold;
  endfunction

  function automatic logic [5:0] exp_flags();
    int n = q.size();
    return {n == DP, n == 0, n >= 14, n <= 2, ov, un};
  endfunction

  task automatic model_reset();
    q.delete();
    hold = '0;
    ov = 0;
    un = 0;
  endtask

  // One clock: drive inputs, advance the model on the edge, sample #1 later.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    int n;
    if0.write = w; if0.din = d; if0.read = r; if0.clear = c;
    @(posedge clk);
    n = q.size();
    if (c) begin
      q.delete(); ov = 0; un = 0;
    end else begin
      if (w && n == DP) ov = 1;
      if (r && n == 0) un = 1;
      if (r && n > 0) hold = q.pop_front();
      if (w && n < DP) begin q.push_back(d); pushes++; end
    end
    #1;
    if0.write = 0; if0.read = 0; if0.clear = 0;
  endtask

  task automatic test_reset();
    if0.write = 0; if0.read = 0; if0.clear = 0; if0.din = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    #1;
    model_reset();
    checks++;
    if ({if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow} !== 6'b010100) begin
      errors++; $display("FAIL reset_flags got %b want %b", {if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow}, 6'b010100);
    end
    checks++;
    if (if0.count !== 5'd0 || if0.dout !== 32'd0 || if1.dout !== 32'd0) begin
      errors++; $display("FAIL reset_count_dout got count=%0d dout0=%h dout1=%h want 0/0/0", if0.count, if0.dout, if1.dout);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DP; i++) begin
      cycle(1, DW'(i), 0, 0);
      checks++;
      if ({if0.count, if0.almost_empty, if0.almost_full, if0.full} !== {5'(i + 1), (i + 1) <= 2, (i + 1) >= 14, (i + 1) == DP}) begin
        errors++; $display("FAIL fill_%0d got count=%0d ae=%b af=%b full=%b", i, if0.count, if0.almost_empty, if0.almost_full, if0.full);
      end
    end
    cycle(1, 32'hDEAD, 0, 0);
    checks++;
    if (if0.overflow !== 1'b1 || if0.count !== 5'd16) begin
      errors++; $display("FAIL overflow got ov=%b count=%0d want 1/16", if0.overflow, if0.count);
    end
    for (int i = 0; i < DP; i++) begin
      cycle(0, '0, 1, 0);
      checks++;
      if (if0.dout !== DW'(i)) begin
        errors++; $display("FAIL drain_dout_%0d got %h want %h", i, if0.dout, DW'(i));
      end
      checks++;
      if (if1.dout !== exp_fwft_dout()) begin
        errors++; $display("FAIL drain_fwft_%0d got %h want %h", i, if1.dout, exp_fwft_dout());
      end
    end
    checks++;
    if (if0.empty !== 1'b1 || if0.count !== 5'd0) begin
      errors++; $display("FAIL drain_empty got empty=%b count=%0d", if0.empty, if0.count);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want [5];
    want = '{32'd104, 32'd200, 32'd201, 32'd202, 32'd203};
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, DW'(100 + i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, DW'(200 + i), 1, 0);
      checks++;
      if (if0.count !== 5'd5 || if0.dout !== DW'(100 + i)) begin
        errors++; $display("FAIL rw_count_%0d got count=%0d dout=%0d want 5/%0d", i, if0.count, if0.dout, 100 + i);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 1, 0);
      checks++;
      if (if0.dout !== want[i]) begin
        errors++; $display("FAIL rw_order_%0d got %0d want %0d", i, if0.dout, want[i]);
      end
    end
    for (int i = 0; i < DP; i++) cycle(1, DW'(300 + i), 0, 0);
    cycle(1, 32'h5555, 1, 0);
    checks++;
    if (if0.count !== 5'd15 || if0.overflow !== 1'b1 || if0.full !== 1'b0 || if0.dout !== 32'd300) begin
      errors++; $display("FAIL rw_full got count=%0d ov=%b full=%b dout=%0d want 15/1/0/300", if0.count, if0.overflow, if0.full, if0.dout);
    end
  endtask

  task automatic test_underflow();
    cycle(0, '0, 0, 1);
    checks++;
    if (if0.overflow !== 1'b0 || if0.dout !== hold) begin
      errors++; $display("FAIL clear_holds got ov=%b dout=%h want 0/%h", if0.overflow, if0.dout, hold);
    end
    cycle(0, '0, 1, 0);
    checks++;
    if (if0.underflow !== 1'b1 || if0.count !== 5'd0 || if0.dout !== hold) begin
      errors++; $display("FAIL underflow got un=%b count=%0d dout=%h want 1/0/%h", if0.underflow, if0.count, if0.dout, hold);
    end
    cycle(1, 32'h77, 1, 0);
    checks++;
    if (if0.count !== 5'd1 || if0.underflow !== 1'b1 || if0.empty !== 1'b0) begin
      errors++; $display("FAIL wr_rd_empty got count=%0d un=%b empty=%b want 1/1/0", if0.count, if0.underflow, if0.empty);
    end
  endtask

  task automatic test_fwft();
    cycle(0, '0, 0, 1);
    cycle(1, 32'hA5A5A5A5, 0, 0);
    checks++;
    if (if1.empty !== 1'b0 || if1.dout !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL fwft_head got empty=%b dout=%h want 0/a5a5a5a5", if1.empty, if1.dout);
    end
    cycle(0, '0, 0, 0);
    cycle(0, '0, 1, 0);
    checks++;
    if (if1.empty !== 1'b1 || if1.count !== 5'd0 || if1.dout !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL fwft_pop got empty=%b count=%0d dout=%h want 1/0/a5a5a5a5", if1.empty, if1.count, if1.dout);
    end
  endtask

  task automatic test_clear();
    cycle(0, '0, 0, 1);
    cycle(0, '0, 1, 0);
    for (int i = 0; i < 7; i++) cycle(1, $urandom, 0, 0);
    cycle(1, 32'hBEEF, 0, 1);
    checks++;
    if (if0.count !== 5'd0 || if0.empty !== 1'b1 || if0.underflow !== 1'b0 || if0.overflow !== 1'b0) begin
      errors++; $display("FAIL clear_at7 got count=%0d empty=%b un=%b ov=%b want 0/1/0/0", if0.count, if0.empty, if0.underflow, if0.overflow);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(99) < 65, $urandom, $urandom_range(99) < 55, 0);
      checks++;
      if ({if0.count, if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow} !== {5'(q.size()), exp_flags()}) begin
        errors++; $display("FAIL rand_state_%0d got %0d/%b want %0d/%b", i, if0.count,
          {if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow}, q.size(), exp_flags());
      end
      checks++;
      if (if0.dout !== hold || if1.dout !== exp_fwft_dout()) begin
        errors++; $display("FAIL rand_dout_%0d got %h/%h want %h/%h", i, if0.dout, if1.dout, hold, exp_fwft_dout());
      end
    end
  endtask

  task automatic test_reset_mid();
    test_random(20);
    if0.write = 1; if0.din = 32'h1234; if0.read = 1;
    #3 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (if0.count !== 5'd0 || if0.empty !== 1'b1 || if0.dout !== 32'd0 || if1.dout !== 32'd0 || if0.overflow !== 1'b0 || if0.underflow !== 1'b0) begin
      errors++; $display("FAIL reset_mid got count=%0d empty=%b dout=%h/%h ov=%b un=%b", if0.count, if0.empty, if0.dout, if1.dout, if0.overflow, if0.underflow);
    end
    if0.write = 0; if0.read = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    test_random(40);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_underflow();
    test_fwft();
    test_clear();
    cycle(0, '0, 0, 1);
    test_random(100);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
